riscv_dmem_resp: RTL

- Data-memory responder on the core's data port. Serves the core's load/store traffic: memwrite, address (core aluout), writedata and readdata.
- Contains a word-addressed data RAM plus a small MMIO region: free-running cycle counter, TX byte FIFO, status register.
- The FIFO drains through a valid/ready stream toward a UART or testbench sink.
- Reads are combinational, as the single-cycle core requires. All state updates happen on the rising clock edge.

---
 rtl/riscv_dmem_resp.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder for the single-cycle core: word RAM plus MMIO cycle counter, TX FIFO and status.
// Define DMEM_STRICT_EN to flag misaligned or out-of-range accesses on err.
module riscv_dmem_resp #(
   parameter int          DEPTH      = 1024,
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] addr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        err
);

   localparam int        AW         = $clog2(DEPTH);
   localparam int        FW         = $clog2(FIFO_DEPTH);
   localparam logic [FW:0] FULL_COUNT = (FW + 1)'(FIFO_DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [FW-1:0] rd_ptr;
   logic [FW-1:0] wr_ptr;
   logic [FW:0]   count;
   logic [31:0]   cycle_count;
   logic          overflow;

   logic          is_mmio;
   logic          sel_cycle;
   logic          sel_txdata;
   logic          sel_status;
   logic [AW-1:0] ram_index;
   logic          bad_access;
   logic          full;
   logic          empty;
   logic          push_req;
   logic          push_ok;
   logic          pop;
   logic [31:0]   status_word;

   assign is_mmio    = (addr[31:16] == MMIO_BASE[31:16]);
   assign sel_cycle  = is_mmio && (addr[15:2] == 14'd0);
   assign sel_txdata = is_mmio && (addr[15:2] == 14'd1);
   assign sel_status = is_mmio && (addr[15:2] == 14'd2);
   assign ram_index  = addr[AW+1:2];

`ifdef DMEM_STRICT_EN
   logic err_q;

   // Misaligned accesses anywhere, or RAM accesses beyond DEPTH words, are rejected.
   assign bad_access = (addr[1:0] != 2'b00) ||
                       (!is_mmio && (addr[31:AW+2] != '0));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         err_q <= 1'b0;
      else if (bad_access)
         err_q <= 1'b1;
   end

   assign err = err_q;
`else
   logic unused_low_bits;

   assign bad_access      = 1'b0;
   assign err             = 1'b0;
   assign unused_low_bits = ^addr[1:0];
`endif

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign tx_valid = !empty;
   assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
   assign pop      = tx_valid && tx_ready;
   assign push_req = memwrite && sel_txdata && !bad_access;
   // A push into a full FIFO still succeeds when the head leaves in the same cycle.
   assign push_ok  = push_req && (!full || pop);

   assign status_word = {16'h0000, 8'(count), 5'b00000, overflow, empty, full};

   always_comb begin
      readdata = 32'h0000_0000;
      if (bad_access)
         readdata = 32'hDEAD_BEEF;
      else if (!is_mmio)
         readdata = mem[ram_index];
      else if (sel_cycle)
         readdata = cycle_count;
      else if (sel_status)
         readdata = status_word;
   end

   always_ff @(posedge clk) begin
      if (memwrite && !is_mmio && !bad_access)
         mem[ram_index] <= writedata;
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_mem[wr_ptr] <= writedata[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cycle_count <= 32'h0000_0000;
      else
         cycle_count <= cycle_count + 32'd1;
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         overflow <= 1'b0;
      else if (push_req && full && !pop)
         overflow <= 1'b1;
      else if (memwrite && sel_status && !bad_access && writedata[2])
         overflow <= 1'b0;
   end

endmodule
